// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Slave end of the RV32I load/store path. Accepts one load or store at a
//   time, performs byte/half/word access on a little-endian word array with
//   sign/zero extension for loads, and answers after a fixed latency with a
//   one-cycle done pulse. The core stalls on busy.
//
// Parameters
//   ADDR_W   word-address bits; the array holds 2**ADDR_W 32-bit words
//   LATENCY  cycles from request acceptance to the done pulse (1..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   mem_read   in   load request, held until done
//   mem_write  in   store request, held until done
//   func3      in   access size/sign (instruction func3 encoding)
//   addr       in   byte address
//   wdata      in   store data, lanes taken from the LSBs
//   busy       out  request in flight (WAIT or RESP)
//   done       out  one-cycle completion pulse; rdata/err valid with it
//   rdata      out  extended load data; 0 for stores and errors
//   err        out  misaligned access, bad func3, or read+write both high
//
// Handshake: a request is taken on any rising edge where the FSM is IDLE and
// mem_read|mem_write is high. Inputs are then ignored until done has pulsed;
// a request still high when IDLE is re-entered counts as a new request.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Latched request
    logic        rd_q, wr_q;
    logic [2:0]  func3_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic idle, accept, enter_resp;

    assign idle   = (state_q == IDLE);
    assign accept = idle && (mem_read || mem_write);

    // With LATENCY=1 the access happens on the acceptance edge itself, before
    // the latched copies exist, so in IDLE the live inputs are used instead.
    logic        cur_rd, cur_wr;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wdata;

    assign cur_rd    = idle ? mem_read  : rd_q;
    assign cur_wr    = idle ? mem_write : wr_q;
    assign cur_f3    = idle ? func3     : func3_q;
    assign cur_addr  = idle ? addr      : addr_q;
    assign cur_wdata = idle ? wdata     : wdata_q;

    // Upper address bits are ignored: addresses wrap modulo the array size.
    logic [ADDR_W-1:0] widx;
    logic [31:0]       unused_addr_bits;
    assign widx             = cur_addr[ADDR_W+1:2];
    assign unused_addr_bits = cur_addr;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Leave when the decremented count reaches zero.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // ---------------- access decode ----------------
    logic [31:0] word, shifted, load_val, wword;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [3:0]  be;
    logic        cur_err;

    assign word     = mem[widx];
    assign shifted  = word >> {cur_addr[1:0], 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = cur_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        cur_err  = 1'b0;
        be       = 4'b0000;
        wword    = 32'h0;
        load_val = 32'h0;
        if (cur_rd && cur_wr) begin
            cur_err = 1'b1;
        end else if (cur_wr) begin
            case (cur_f3)
                3'b000: begin
                    be    = 4'b0001 << cur_addr[1:0];
                    wword = {4{cur_wdata[7:0]}};
                end
                3'b001: begin
                    if (cur_addr[0]) begin
                        cur_err = 1'b1;
                    end else begin
                        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                        wword = {2{cur_wdata[15:0]}};
                    end
                end
                3'b010: begin
                    if (cur_addr[1:0] != 2'b00) begin
                        cur_err = 1'b1;
                    end else begin
                        be    = 4'b1111;
                        wword = cur_wdata;
                    end
                end
                default: cur_err = 1'b1;
            endcase
        end else begin
            case (cur_f3)
                3'b000: load_val = {{24{byte_sel[7]}}, byte_sel};
                3'b100: load_val = {24'h0, byte_sel};
                3'b001: begin
                    if (cur_addr[0]) cur_err = 1'b1;
                    else             load_val = {{16{half_sel[15]}}, half_sel};
                end
                3'b101: begin
                    if (cur_addr[0]) cur_err = 1'b1;
                    else             load_val = {16'h0, half_sel};
                end
                3'b010: begin
                    if (cur_addr[1:0] != 2'b00) cur_err = 1'b1;
                    else                        load_val = word;
                end
                default: cur_err = 1'b1;
            endcase
        end
    end

    // ---------------- state and response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q    <= mem_read;
                wr_q    <= mem_write;
                func3_q <= func3;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            // Response is captured on the edge entering RESP and cleared after.
            rdata_q <= (enter_resp && cur_rd && !cur_err) ? load_val : 32'h0;
            err_q   <= enter_resp && cur_err;
        end
    end

    // Array write; a store discarded by reset never reaches RESP, so it never
    // commits.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_wr && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign busy  = !idle;
    assign done  = (state_q == RESP);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mrd, mwr;
    logic [2:0]  f3_v [2];
    logic [31:0] ad_v [2];
    logic [31:0] wd_v [2];
    logic [1:0]  busy_v, done_v, err_v;
    logic [31:0] rdata_v [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0: default latency 2; instance 1: latency 1
    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mrd[0]), .mem_write(mwr[0]),
        .func3(f3_v[0]), .addr(ad_v[0]), .wdata(wd_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .err(err_v[0])
    );

    data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(mrd[1]), .mem_write(mwr[1]),
        .func3(f3_v[1]), .addr(ad_v[1]), .wdata(wd_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .err(err_v[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One full transaction: wait for IDLE, present the request at a negedge,
    // count negedges until done. lat = 0 means the bound expired.
    task automatic do_op(input int sel, input bit rd, input bit wr, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] w,
                         output logic [31:0] r, output logic e, output int lat,
                         output bit busy_ok);
        int guard;
        @(negedge clk);
        guard = 0;
        while (busy_v[sel] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        mrd[sel] = rd; mwr[sel] = wr; f3_v[sel] = f; ad_v[sel] = a; wd_v[sel] = w;
        lat = 0; r = 32'h0; e = 1'b0; busy_ok = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (!busy_v[sel]) busy_ok = 1'b0;
            if (done_v[sel]) begin
                lat = c; r = rdata_v[sel]; e = err_v[sel];
                break;
            end
        end
        mrd[sel] = 1'b0; mwr[sel] = 1'b0;
    endtask

    // ---------------- behavioural reference (byte array, region 0..63) ------
    logic [7:0] mb [64];

    task automatic ref_op(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] w, output logic [31:0] r, output logic e);
        int o;
        logic [15:0] h;
        logic [7:0]  b;
        o = int'(a % 64);
        r = 32'h0; e = 1'b0;
        b = mb[o];
        h = {mb[(o | 1)], mb[o & 62]};
        if (rd && wr) e = 1'b1;
        else if (wr) begin
            if (f == 3'd0) mb[o] = w[7:0];
            else if (f == 3'd1 && o % 2 == 0) begin mb[o] = w[7:0]; mb[o+1] = w[15:8]; end
            else if (f == 3'd2 && o % 4 == 0)
                for (int k = 0; k < 4; k++) mb[o+k] = w[8*k +: 8];
            else e = 1'b1;
        end else begin
            case (f)
                3'd0: r = {{24{b[7]}}, b};
                3'd4: r = {24'h0, b};
                3'd1: if (o % 2 == 0) r = {{16{h[15]}}, h}; else e = 1'b1;
                3'd5: if (o % 2 == 0) r = {16'h0, h}; else e = 1'b1;
                3'd2: if (o % 4 == 0) r = {mb[o+3], mb[o+2], mb[o+1], mb[o]}; else e = 1'b1;
                default: e = 1'b1;
            endcase
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [31:0] r, er, w, a;
        logic        e, ee;
        int          lat;
        bit          bok, rd, wr;
        logic [2:0]  f;
        logic [3:0]  pat;

        mrd = '0; mwr = '0;
        for (int i = 0; i < 2; i++) begin f3_v[i] = '0; ad_v[i] = '0; wd_v[i] = '0; end

        //          rd wr f3      addr    wdata         exp_rdata     err
        tbl[0]  = '{0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 0};
        tbl[1]  = '{1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0};
        tbl[2]  = '{0, 1, 3'b000, 32'h13, 32'h00000080, 32'h00000000, 0};
        tbl[3]  = '{1, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0};
        tbl[4]  = '{1, 0, 3'b100, 32'h13, 32'h0,        32'h00000080, 0};
        tbl[5]  = '{1, 0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0};
        tbl[6]  = '{0, 1, 3'b001, 32'h11, 32'h00001234, 32'h00000000, 1};
        tbl[7]  = '{1, 0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0};
        tbl[8]  = '{0, 1, 3'b001, 32'h12, 32'h00008001, 32'h00000000, 0};
        tbl[9]  = '{1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 0};
        tbl[10] = '{1, 0, 3'b101, 32'h12, 32'h0,        32'h00008001, 0};
        tbl[11] = '{0, 1, 3'b010, 32'h20, 32'h55667788, 32'h00000000, 0};
        tbl[12] = '{1, 1, 3'b010, 32'h20, 32'h0BADF00D, 32'h00000000, 1};
        tbl[13] = '{1, 0, 3'b010, 32'h20, 32'h0,        32'h55667788, 0};
        tbl[14] = '{1, 0, 3'b011, 32'h20, 32'h0,        32'h00000000, 1};
        tbl[15] = '{1, 0, 3'b010, 32'h21, 32'h0,        32'h00000000, 1};
        tbl[16] = '{1, 0, 3'b100, 32'h21, 32'h0,        32'h00000077, 0};
        tbl[17] = '{1, 0, 3'b001, 32'h22, 32'h0,        32'h00005566, 0};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", 32'(busy_v[i]), 32'h0);
            chk("reset_done", 32'(done_v[i]), 32'h0);
            chk("reset_rdata", rdata_v[i], 32'h0);
            chk("reset_err", 32'(err_v[i]), 32'h0);
        end
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 18; i++) begin
            do_op(0, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, r, e, lat, bok);
            chk($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("tbl%0d_busy", i), 32'(bok), 32'h1);
        end

        // ---------------- reset during WAIT discards the store ----------------
        do_op(0, 0, 1, 3'b010, 32'h30, 32'hA5A5A5A5, r, e, lat, bok);
        @(negedge clk);
        mrd[0] = 1'b0; mwr[0] = 1'b1; f3_v[0] = 3'b010; ad_v[0] = 32'h30; wd_v[0] = 32'h11111111;
        @(negedge clk);
        chk("rst_mid_busy_before", 32'(busy_v[0]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy_v[0]), 32'h0);
        chk("rst_mid_done", 32'(done_v[0]), 32'h0);
        chk("rst_mid_rdata", rdata_v[0], 32'h0);
        mwr[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 1, 0, 3'b010, 32'h30, 32'h0, r, e, lat, bok);
        chk("rst_mid_old_value", r, 32'hA5A5A5A5);
        chk("rst_mid_err", 32'(e), 32'h0);

        // ---------------- address wrap, both latencies ----------------
        for (int s = 0; s < 2; s++) begin
            do_op(s, 0, 1, 3'b010, 32'h1000, 32'hCAFEF00D, r, e, lat, bok);
            chk($sformatf("wrap_sw_lat_%0d", s), 32'(lat), (s == 0) ? 32'd2 : 32'd1);
            chk($sformatf("wrap_sw_err_%0d", s), 32'(e), 32'h0);
            do_op(s, 1, 0, 3'b010, 32'h0, 32'h0, r, e, lat, bok);
            chk($sformatf("wrap_lw_%0d", s), r, 32'hCAFEF00D);
            chk($sformatf("wrap_lw_lat_%0d", s), 32'(lat), (s == 0) ? 32'd2 : 32'd1);
        end

        // LATENCY=1: a held request is re-accepted every second cycle.
        @(negedge clk);
        mrd[1] = 1'b1; f3_v[1] = 3'b010; ad_v[1] = 32'h0;
        pat = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pat[3-c] = done_v[1];
            if (done_v[1]) chk($sformatf("b2b_rdata_%0d", c), rdata_v[1], 32'hCAFEF00D);
        end
        mrd[1] = 1'b0;
        chk("b2b_done_pattern", 32'(pat), 32'hA);

        // ---------------- randomized against the reference model ----------------
        for (int k = 0; k < 16; k++) begin
            w = $urandom;
            ref_op(0, 1, 3'b010, 32'(4 * k), w, er, ee);
            do_op(0, 0, 1, 3'b010, 32'(4 * k), w, r, e, lat, bok);
        end
        for (int k = 0; k < 80; k++) begin
            rd = ($urandom_range(0, 1) == 1);
            wr = !rd;
            if ($urandom_range(0, 9) == 0) begin rd = 1; wr = 1; end
            f = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
            w = $urandom;
            ref_op(rd, wr, f, a, w, er, ee);
            do_op(0, rd, wr, f, a, w, r, e, lat, bok);
            chk($sformatf("rnd%0d_rdata(a=%h f=%0d rd=%0d wr=%0d)", k, a, f, rd, wr), r, er);
            chk($sformatf("rnd%0d_err", k), 32'(e), 32'(ee));
            chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
